// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Central D-stage stall scheduler for a 5-stage MIPS pipeline
//            (F/D/E/M/W). Tracks in-flight GPR writes in E and M as
//            {valid, write address, Tnew} records and compares the D-stage
//            source registers (with their Tuse) against them. Also sequences
//            the shared mult/div unit with a busy counter and blocks
//            HI/LO-accessing instructions while that unit runs.
// Optional : HAZARD_STALL_CONTROLLER_STATS_EN adds output stall_count[31:0],
//            a saturating count of stalled cycles, cleared by reset only.
// Ports    :
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   d_rs, d_rt   in   D-stage source register fields
//   d_rs_tuse    in   cycles until rs is needed (0..2), 3 = unused
//   d_rt_tuse    in   same encoding for rt
//   d_wen        in   D instruction writes a GPR
//   d_wa         in   D destination register
//   d_tnew       in   cycles after entering E until result is forwardable
//   d_md_start   in   00 none, 01 mult/multu, 10 div/divu, 11 treated as none
//   d_md_use     in   D instruction touches HI/LO or starts the md unit
//   flush        in   exception/eret pipeline flush
//   stall        out  freeze PC and F/D, bubble into D/E
//   md_busy      out  mult/div busy counter is nonzero
//   stall_count  out  (optional) saturating stalled-cycle count
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic       d_wen,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_start,
    input  logic       d_md_use,
    input  logic       flush,
    output logic       stall,
    output logic       md_busy
`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam logic [1:0]       c_MD_MULT   = 2'b01;
    localparam logic [1:0]       c_MD_DIV    = 2'b10;
    localparam logic [1:0]       c_TUSE_NONE = 2'd3;
    localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // Saturating decrement of a remaining-latency field.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard and md-unit state
    // ------------------------------------------------------------------
    logic             r_e_v_q,    w_e_v_d;
    logic [4:0]       r_e_wa_q,   w_e_wa_d;
    logic [1:0]       r_e_tnew_q, w_e_tnew_d;
    logic             r_e_md_q,   w_e_md_d;
    logic             r_m_v_q,    w_m_v_d;
    logic [4:0]       r_m_wa_q,   w_m_wa_d;
    logic [1:0]       r_m_tnew_q, w_m_tnew_d;
    logic [CNT_W-1:0] r_busy_q,   w_busy_d;

    logic w_rs_hazard;
    logic w_rt_hazard;
    logic w_md_hazard;
    logic w_md_issue;
    logic w_stall;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational from inputs and state)
    // ------------------------------------------------------------------
    always_comb begin
        w_md_issue = (d_md_start == c_MD_MULT) || (d_md_start == c_MD_DIV);

        // The M record already carries the decremented Tnew, and the compare
        // uses one further step of decrement as its remaining latency.
        w_rs_hazard = (d_rs_tuse != c_TUSE_NONE) && (d_rs != 5'd0) &&
                      ((r_e_v_q && (r_e_wa_q == d_rs) && (r_e_tnew_q > d_rs_tuse)) ||
                       (r_m_v_q && (r_m_wa_q == d_rs) && (sat_dec(r_m_tnew_q) > d_rs_tuse)));

        w_rt_hazard = (d_rt_tuse != c_TUSE_NONE) && (d_rt != 5'd0) &&
                      ((r_e_v_q && (r_e_wa_q == d_rt) && (r_e_tnew_q > d_rt_tuse)) ||
                       (r_m_v_q && (r_m_wa_q == d_rt) && (sat_dec(r_m_tnew_q) > d_rt_tuse)));

        // r_e_md_q covers the issuing op in E; the counter is already loaded
        // then, so it is a belt-and-braces term for the same condition.
        w_md_hazard = d_md_use && ((r_busy_q != '0) || r_e_md_q);

        w_stall = w_rs_hazard || w_rt_hazard || w_md_hazard;
    end

    // ------------------------------------------------------------------
    // Next-state: advance the scoreboard, run the busy counter
    // ------------------------------------------------------------------
    always_comb begin
        w_m_v_d    = r_e_v_q;
        w_m_wa_d   = r_e_wa_q;
        w_m_tnew_d = sat_dec(r_e_tnew_q);

        if (w_stall) begin
            // Bubble into E; D holds its instruction.
            w_e_v_d    = 1'b0;
            w_e_wa_d   = 5'd0;
            w_e_tnew_d = 2'd0;
            w_e_md_d   = 1'b0;
        end else begin
            w_e_v_d    = d_wen && (d_wa != 5'd0);
            w_e_wa_d   = d_wa;
            w_e_tnew_d = d_tnew;
            w_e_md_d   = w_md_issue;
        end

        if (!w_stall && w_md_issue) begin
            w_busy_d = (d_md_start == c_MD_MULT) ? c_MULT_LOAD : c_DIV_LOAD;
        end else if (r_busy_q != '0) begin
            w_busy_d = r_busy_q - 1'b1;
        end else begin
            w_busy_d = r_busy_q;
        end

        // Flush kills everything in flight, including the md operation.
        if (flush) begin
            w_e_v_d    = 1'b0;
            w_e_wa_d   = 5'd0;
            w_e_tnew_d = 2'd0;
            w_e_md_d   = 1'b0;
            w_m_v_d    = 1'b0;
            w_m_wa_d   = 5'd0;
            w_m_tnew_d = 2'd0;
            w_busy_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_v_q    <= 1'b0;
            r_e_wa_q   <= 5'd0;
            r_e_tnew_q <= 2'd0;
            r_e_md_q   <= 1'b0;
            r_m_v_q    <= 1'b0;
            r_m_wa_q   <= 5'd0;
            r_m_tnew_q <= 2'd0;
            r_busy_q   <= '0;
        end else begin
            r_e_v_q    <= w_e_v_d;
            r_e_wa_q   <= w_e_wa_d;
            r_e_tnew_q <= w_e_tnew_d;
            r_e_md_q   <= w_e_md_d;
            r_m_v_q    <= w_m_v_d;
            r_m_wa_q   <= w_m_wa_d;
            r_m_tnew_q <= w_m_tnew_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign stall   = w_stall;
    assign md_busy = (r_busy_q != '0);

`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
    // ------------------------------------------------------------------
    // Stalled-cycle statistics: saturating, survives flush
    // ------------------------------------------------------------------
    logic [31:0] r_stall_count_q, w_stall_count_d;

    always_comb begin
        w_stall_count_d = r_stall_count_q;
        if (w_stall && !flush && (r_stall_count_q != 32'hFFFF_FFFF)) begin
            w_stall_count_d = r_stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count_q <= 32'd0;
        end else begin
            r_stall_count_q <= w_stall_count_d;
        end
    end

    assign stall_count = r_stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Directed self-checking bench for hazard_stall_controller.
//            Inputs change 1 time unit after the rising edge; outputs are
//            compared 1 time unit later, well before the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew, d_md_start;
    logic       d_wen, d_md_use, flush;
    logic       stall, md_busy;
`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hazard_stall_controller #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_wen      (d_wen),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_use   (d_md_use),
        .flush      (flush),
        .stall      (stall),
        .md_busy    (md_busy)
`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a D-stage instruction and let the combinational outputs settle.
    task automatic drive(input logic [4:0] rs, input logic [1:0] rs_tu,
                         input logic [4:0] rt, input logic [1:0] rt_tu,
                         input logic wen, input logic [4:0] wa, input logic [1:0] tnew,
                         input logic [1:0] mds, input logic mdu);
        d_rs = rs; d_rs_tuse = rs_tu; d_rt = rt; d_rt_tuse = rt_tu;
        d_wen = wen; d_wa = wa; d_tnew = tnew; d_md_start = mds; d_md_use = mdu;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
    endtask

    task automatic drain();
        nop(); tick(); tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        nop();
        tick();
        reset = 1'b0;
        nop();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b expected 0", md_busy); end
    endtask

    task automatic test_load_use();
        // lw $1 (tnew=2) then addu rs=$1 (tuse=1): one stall cycle.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd1, 2'd2, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_issue_stall: got %b expected 0", stall); end
        tick();
        drive(5'd1, 2'd1, 5'd0, 2'd3, 1'b1, 5'd2, 2'd1, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b expected 0", stall); end
        tick();
        drain();
        // lw $1 then store data rs=$1 with tuse=2: no stall.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd1, 2'd2, 2'b00, 1'b0);
        tick();
        drive(5'd1, 2'd2, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_store_data: got %b expected 0", stall); end
        tick();
        drain();
    endtask

    task automatic test_zero_reg();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg_e: got %b expected 0", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg_m: got %b expected 0", stall); end
        drain();
    endtask

    task automatic test_back_to_back();
        // addu $3 then beq rs=$3 (tuse=0): one stall cycle.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 2'b00, 1'b0);
        tick();
        drive(5'd3, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_rs_stall: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_rs_release: got %b expected 0", stall); end
        tick();
        drain();
        // beq two cycles after the addu: no stall.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd3, 2'd1, 2'b00, 1'b0);
        tick();
        nop();
        tick();
        drive(5'd3, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL gap2_no_stall: got %b expected 0", stall); end
        tick();
        drain();
        // rt-side: addu $4 then consumer rt=$4 (tuse=0).
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd4, 2'd1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 2'd3, 5'd4, 2'd0, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_rt_stall: got %b expected 1", stall); end
        tick();
        drain();
    endtask

    task automatic test_m_side();
        // Producer with tnew=3: E holds 3, M holds 2 whose remaining latency 1 > tuse 0.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd7, 2'd3, 2'b00, 1'b0);
        tick();
        drive(5'd0, 2'd3, 5'd7, 2'd0, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mside_e_stall: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mside_m_stall: got %b expected 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL mside_release: got %b expected 0", stall); end
        tick();
        drain();
    endtask

    task automatic test_md(input logic [1:0] kind, input int n);
        drive(5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, kind, 1'b1);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL md_issue_stall kind=%0d: got %b expected 0", kind, stall); end
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd10, 2'd1, 2'b00, 1'b1);
        n_checks++;
        if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_set kind=%0d: got %b expected 1", kind, md_busy); end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL md_stall kind=%0d cyc=%0d: got %b expected 1", kind, i, stall); end
            tick();
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL md_release kind=%0d: got %b expected 0", kind, stall); end
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_busy_clear kind=%0d: got %b expected 0", kind, md_busy); end
        tick();
        drain();
    endtask

    task automatic test_flush();
        // div, mflo waits, flush on the third stalled cycle.
        drive(5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 2'b10, 1'b1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd10, 2'd1, 2'b00, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_stall: got %b expected 1", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_md_busy: got %b expected 0", md_busy); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_md_stall: got %b expected 0", stall); end
        tick();
        drain();
        // Flush with a scoreboard hazard pending: M must come up empty.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd6, 2'd3, 2'b00, 1'b0);
        tick();
        flush = 1'b1;
        drive(5'd6, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_sb_pre: got %b expected 1", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_sb_post: got %b expected 0", stall); end
        drain();
    endtask

    task automatic test_reset_mid();
        // div -> busy 10; two idle edges -> 8; lw $5 enters E -> busy 7.
        drive(5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 2'b10, 1'b1);
        tick();
        nop(); tick(); tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd5, 2'd2, 2'b00, 1'b0);
        tick();
        drive(5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 2'b00, 1'b0);
        n_checks++;
        if ((stall !== 1'b1) || (md_busy !== 1'b1)) begin
            n_fail++; $display("FAIL reset_mid_pre: stall=%b md_busy=%b expected 1 1", stall, md_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall: got %b expected 0", stall); end
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_md_busy: got %b expected 0", md_busy); end
`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
        n_checks++;
        if (stall_count !== 32'd0) begin n_fail++; $display("FAIL stats_after_reset: got %0d expected 0", stall_count); end
`endif
        drain();
    endtask

`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
    task automatic test_stats();
        drive(5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 2'b01, 1'b1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd10, 2'd1, 2'b00, 1'b1);
        tick(); tick(); tick();
        n_checks++;
        if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stats_three: got %0d expected 3", stall_count); end
        // Flushed stall cycle is not counted, and flush does not clear.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stats_flush: got %0d expected 3", stall_count); end
        drain();
    endtask
`endif

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        d_rs = 5'd0; d_rt = 5'd0; d_wa = 5'd0;
        d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; d_tnew = 2'd0; d_md_start = 2'b00;
        d_wen = 1'b0; d_md_use = 1'b0;

        test_reset();
        test_load_use();
        test_zero_reg();
        test_back_to_back();
        test_m_side();
        test_md(2'b10, 10);
        test_md(2'b01, 5);
        test_flush();
        test_reset_mid();
`ifdef HAZARD_STALL_CONTROLLER_STATS_EN
        test_stats();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
